sdram_req_queue: RTL and testbench
==================================

SDRAM_REQ_QUEUE -- requirements
Module: sdram_req_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of posted-request entries (power of two, 2..16).
REQ-002 SHALL have clk  in  1  system clock, same clock as the SDRAM controller.
REQ-003 SHALL have reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have c_addr  in  24:1  client word address.
REQ-005 SHALL have c_wrl / c_wrh  in  1 each  low/high byte write strobes; both 0 means read.
REQ-006 SHALL have c_din  in  16  client write data.
REQ-007 SHALL have c_valid  in  1  client request present.
REQ-008 SHALL have c_ready  out  1  request accepted when c_valid & c_ready.
REQ-009 SHALL have c_dout  out  16  read data.
REQ-010 SHALL have c_rvalid  out  1  one-cycle read-data strobe.
REQ-011 SHALL have m_addr  out  24:1; m_wrl, m_wrh  out  1; m_din  out  16  controller port request fields.
REQ-012 SHALL have m_req  out  1  toggle request; m_ack  in  1  toggle acknowledge; m_dout  in  16  controller read data.

Function
REQ-013 SHALL store accepted requests (addr, wrl, wrh, din) in a DEPTH-entry FIFO; issue order SHALL equal acceptance order.
REQ-014 c_ready SHALL be 1 when FIFO not full and no read is pending (read pending = a read accepted and its c_rvalid not yet produced).
REQ-015 Writes SHALL be posted: the client sees completion at acceptance; no response strobe.
REQ-016 Issue FSM states: IDLE, WAIT; IDLE with FIFO non-empty SHALL drive head fields onto m_* and toggle m_req in the same cycle, go to WAIT.
REQ-017 m_* fields SHALL be held stable from the toggle until m_ack == m_req.
REQ-018 In WAIT, m_ack == m_req SHALL pop the head and return to IDLE; the next issue SHALL occur no earlier than the following cycle.
REQ-019 Completed read: c_dout SHALL capture m_dout on the cycle m_ack matches, and c_rvalid SHALL pulse 1 the next cycle; c_dout SHALL hold until the next read completes.
REQ-020 Simultaneous accept and pop SHALL leave the occupancy count unchanged; full with a simultaneous pop SHALL still report c_ready = 0 that cycle (ready from registered count only).
REQ-021 Pointers SHALL wrap modulo DEPTH; occupancy counter width SHALL be log2(DEPTH)+1.
REQ-022 Client strobes with c_valid = 0 SHALL be ignored.

Reset
REQ-023 reset_n low SHALL asynchronously clear FIFO pointers, count, read-pending, c_rvalid, c_dout, m_addr, m_wrl, m_wrh, m_din to 0 and FSM to IDLE.
REQ-024 On reset m_req SHALL be loaded with the current m_ack value, so no spurious request is seen; a request in flight at reset SHALL be abandoned and its late ack ignored.
REQ-025 c_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-026 With SDRAM_RQ_MERGE_EN defined: an accepted write to the same c_addr as the FIFO tail entry, where the tail is a write not yet issued, SHALL merge into it (set strobes OR'd, bytes replaced per new strobe) with no new entry; without it every write SHALL occupy its own entry.

Verification
REQ-027 Reset release, single read of 0x000100, controller acks after 6 cycles with m_dout = 0xBEEF -> c_rvalid one pulse, c_dout = 0xBEEF, c_ready low from accept until pulse.
REQ-028 Five back-to-back writes, DEPTH = 4, ack held -> c_ready low after the 4th write; then issue order 1..5 on m_addr with m_req toggling once per write.
REQ-029 Write 0x1234 to A, then read A -> read issued after write; returned data from the controller, not forwarded.
REQ-030 Reset asserted while in WAIT -> m_req == m_ack after reset, a later stray m_ack toggle produces no pop and no c_rvalid.
REQ-031 MERGE_EN: write c_wrl = 1, 0x00AA then c_wrh = 1, 0xBB00 to same addr while stalled -> one entry issued, m_wrl = m_wrh = 1, m_din = 0xBBAA; without MERGE_EN -> two issues.
REQ-032 Accept and pop in the same cycle at count 2 -> count stays 2, no entry lost or duplicated.

Source files
------------

// File: rtl/sdram_req_queue_if.sv
// Client and controller-port signals of the SDRAM request queue.
// slave is the queue itself; master is whoever drives the client and controller side.
interface sdram_req_queue_if;
  logic [24:1] c_addr;
  logic        c_wrl;
  logic        c_wrh;
  logic [15:0] c_din;
  logic        c_valid;
  logic        c_ready;
  logic [15:0] c_dout;
  logic        c_rvalid;

  logic [24:1] m_addr;
  logic        m_wrl;
  logic        m_wrh;
  logic [15:0] m_din;
  logic        m_req;
  logic        m_ack;
  logic [15:0] m_dout;

  modport master (
    output c_addr, c_wrl, c_wrh, c_din, c_valid, m_ack, m_dout,
    input  c_ready, c_dout, c_rvalid, m_addr, m_wrl, m_wrh, m_din, m_req
  );

  modport slave (
    input  c_addr, c_wrl, c_wrh, c_din, c_valid, m_ack, m_dout,
    output c_ready, c_dout, c_rvalid, m_addr, m_wrl, m_wrh, m_din, m_req
  );
endinterface

// File: rtl/sdram_req_queue.sv
// Posted-write / blocking-read request FIFO in front of a toggle-handshake SDRAM port.
// Define SDRAM_RQ_MERGE_EN to merge same-address writes into the unissued FIFO tail.
module sdram_req_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              reset_n,
  sdram_req_queue_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;
  state_e state_q, state_d;

  logic [24:1]   addr_mem [DEPTH];
  logic [15:0]   din_mem  [DEPTH];
  logic          wrl_mem  [DEPTH];
  logic          wrh_mem  [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          rd_pend_q;
  logic          c_rvalid_q;
  logic [15:0]   c_dout_q;
  logic [24:1]   m_addr_q;
  logic          m_wrl_q, m_wrh_q, m_req_q;
  logic [15:0]   m_din_q;

  logic ready, accept, is_read, push, merge, acked, issue, pop, read_done;

  assign ready     = (count_q != Full) && !rd_pend_q;
  assign accept    = bus.c_valid && ready;
  assign is_read   = !bus.c_wrl && !bus.c_wrh;
  assign acked     = (bus.m_ack == m_req_q);
  assign read_done = pop && !m_wrl_q && !m_wrh_q;
  assign push      = accept && !merge;

`ifdef SDRAM_RQ_MERGE_EN
  logic [AW-1:0] tail_ptr;
  assign tail_ptr = wr_ptr_q - AW'(1);
  // With one entry the tail is the head, which is already issued or issuing this cycle.
  assign merge = accept && !is_read && (count_q >= CW'(2)) &&
                 (wrl_mem[tail_ptr] || wrh_mem[tail_ptr]) && (addr_mem[tail_ptr] == bus.c_addr);
`else
  assign merge = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.c_addr;
      wrl_mem[wr_ptr_q]  <= bus.c_wrl;
      wrh_mem[wr_ptr_q]  <= bus.c_wrh;
      din_mem[wr_ptr_q]  <= bus.c_din;
    end
`ifdef SDRAM_RQ_MERGE_EN
    else if (merge) begin
      wrl_mem[tail_ptr] <= wrl_mem[tail_ptr] | bus.c_wrl;
      wrh_mem[tail_ptr] <= wrh_mem[tail_ptr] | bus.c_wrh;
      if (bus.c_wrl) din_mem[tail_ptr][7:0]  <= bus.c_din[7:0];
      if (bus.c_wrh) din_mem[tail_ptr][15:8] <= bus.c_din[15:8];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (accept && is_read) rd_pend_q <= 1'b1;
      else if (read_done)    rd_pend_q <= 1'b0;
    end
  end

  // Issue FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (count_q != '0) state_d = StWait;
      StWait: if (acked)         state_d = StIdle;
      default:                   state_d = StIdle;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    pop   = 1'b0;
    unique case (state_q)
      StIdle:  issue = (count_q != '0);
      StWait:  pop   = acked;
      default: ;
    endcase
  end

  // m_req tracks m_ack while idle so a late ack from an abandoned request is absorbed;
  // a new request is always the complement of the current ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_req_q  <= bus.m_ack;
      m_addr_q <= '0;
      m_wrl_q  <= 1'b0;
      m_wrh_q  <= 1'b0;
      m_din_q  <= '0;
    end else if (issue) begin
      m_req_q  <= ~bus.m_ack;
      m_addr_q <= addr_mem[rd_ptr_q];
      m_wrl_q  <= wrl_mem[rd_ptr_q];
      m_wrh_q  <= wrh_mem[rd_ptr_q];
      m_din_q  <= din_mem[rd_ptr_q];
    end else if (state_q == StIdle) begin
      m_req_q  <= bus.m_ack;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_dout_q   <= '0;
      c_rvalid_q <= 1'b0;
    end else begin
      c_rvalid_q <= read_done;
      if (read_done) c_dout_q <= bus.m_dout;
    end
  end

  assign bus.c_ready  = ready;
  assign bus.c_dout   = c_dout_q;
  assign bus.c_rvalid = c_rvalid_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wrl    = m_wrl_q;
  assign bus.m_wrh    = m_wrh_q;
  assign bus.m_din    = m_din_q;
  assign bus.m_req    = m_req_q;
endmodule

// File: tb/tb_sdram_req_queue.sv
// Scoreboard bench for sdram_req_queue: reference FIFO/memory model, toggle-handshake
// controller model, directed corner cases and a randomized phase.
module tb_sdram_req_queue;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [24:1] addr;
    logic        wrl;
    logic        wrh;
    logic [15:0] din;
  } req_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sdram_req_queue_if bus ();
  sdram_req_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  req_t        exp_iss [$];
  logic [15:0] exp_rd  [$];
  logic [15:0] ref_mem [int];
  logic [15:0] ctl_mem [int];

  int checks = 0;
  int errors = 0;
  int issues = 0;
  int rvalids = 0;
  bit hold = 1'b0;
  bit release_one = 1'b0;
  bit ctl_off = 1'b0;
  bit flush = 1'b0;
  bit ctl_busy = 1'b0;
  int fixed_delay = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [15:0] merge_bytes(input logic [15:0] old, input logic wl,
                                              input logic wh, input logic [15:0] d);
    return {wh ? d[15:8] : old[15:8], wl ? d[7:0] : old[7:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: requests issue in acceptance order, reads return the memory image
  // produced by all earlier accepted writes.
  task automatic model_accept(input logic [24:1] a, input logic wl, input logic wh,
                              input logic [15:0] d);
    int k;
    logic [15:0] old;
    req_t r;
    k = int'(a);
    old = ref_mem.exists(k) ? ref_mem[k] : 16'h0;
    if (!wl && !wh) begin
      exp_rd.push_back(old);
      r = '{addr: a, wrl: 1'b0, wrh: 1'b0, din: d};
      exp_iss.push_back(r);
      return;
    end
    ref_mem[k] = merge_bytes(old, wl, wh, d);
`ifdef SDRAM_RQ_MERGE_EN
    if (exp_iss.size() > 0) begin
      r = exp_iss.pop_back();
      if ((r.wrl || r.wrh) && r.addr == a) begin
        r.din = merge_bytes(r.din, wl, wh, d);
        r.wrl = r.wrl | wl;
        r.wrh = r.wrh | wh;
        exp_iss.push_back(r);
        return;
      end
      exp_iss.push_back(r);
    end
`endif
    r = '{addr: a, wrl: wl, wrh: wh, din: d};
    exp_iss.push_back(r);
  endtask

  // Must be entered shortly after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [24:1] a, input logic wl, input logic wh,
                      input logic [15:0] d, output bit ok);
    ok = 1'b0;
    bus.c_addr  = a;
    bus.c_wrl   = wl;
    bus.c_wrh   = wh;
    bus.c_din   = d;
    bus.c_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (bus.c_ready === 1'b1) begin
        model_accept(a, wl, wh, d);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) fail_now("accept_timeout", $sformatf("addr %0h not accepted in 400 cycles", a));
    bus.c_valid = 1'b0;
    bus.c_addr  = 24'($urandom);
    bus.c_wrl   = 1'($urandom);
    bus.c_wrh   = 1'($urandom);
    bus.c_din   = 16'($urandom);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = (exp_iss.size() == 0) && (exp_rd.size() == 0) && !ctl_busy;
    end
    if (!done) fail_now("drain_timeout", $sformatf("%0d issues and %0d reads still expected",
                                                   exp_iss.size(), exp_rd.size()));
    cyc(1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush = 1'b1;
    exp_iss.delete();
    exp_rd.delete();
    ref_mem.delete();
    ctl_mem.delete();
    cyc(3);
    flush = 1'b0;
    reset_n = 1'b1;
  endtask

  // Controller model: serves one toggle request at a time after a delay.
  initial begin : ctl
    req_t cur;
    req_t got;
    int wait_n;
    int k;
    bus.m_ack  = 1'b0;
    bus.m_dout = 16'h0;
    forever begin
      @(negedge clk);
      if (flush) begin
        ctl_busy = 1'b0;
        release_one = 1'b0;
      end else if (ctl_off) begin
      end else if (!ctl_busy) begin
        if (bus.m_req !== bus.m_ack) begin
          cur = '{addr: bus.m_addr, wrl: bus.m_wrl, wrh: bus.m_wrh, din: bus.m_din};
          ctl_busy = 1'b1;
          issues++;
          wait_n = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
          if (exp_iss.size() == 0) fail_now("issue_unexpected", $sformatf("addr %0h", cur.addr));
          else check("issue_order", 64'(cur), 64'(exp_iss.pop_front()));
        end
      end else if (release_one || (!hold && wait_n == 0)) begin
        got = '{addr: bus.m_addr, wrl: bus.m_wrl, wrh: bus.m_wrh, din: bus.m_din};
        check("fields_stable", 64'(got), 64'(cur));
        k = int'(cur.addr);
        if (!cur.wrl && !cur.wrh) begin
          bus.m_dout = ctl_mem.exists(k) ? ctl_mem[k] : 16'h0;
        end else begin
          ctl_mem[k] = merge_bytes(ctl_mem.exists(k) ? ctl_mem[k] : 16'h0, cur.wrl, cur.wrh,
                                   cur.din);
          bus.m_dout = 16'($urandom);
        end
        bus.m_ack = bus.m_req;
        ctl_busy = 1'b0;
        release_one = 1'b0;
      end else if (!hold) begin
        wait_n--;
      end
    end
  end

  initial begin : rd_mon
    forever begin
      @(negedge clk);
      if (reset_n && bus.c_rvalid === 1'b1) begin
        rvalids++;
        if (exp_rd.size() == 0) fail_now("rvalid_unexpected", $sformatf("c_dout %0h", bus.c_dout));
        else check("read_data", 64'(bus.c_dout), 64'(exp_rd.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    bit ok;
    bit ready_low;
    bit seen;
    int i0;
    int exp_n;
    logic [24:1] a;
    logic [24:1] last_addr;
    logic wl;
    logic wh;

    bus.c_valid = 1'b0;
    bus.c_addr  = '0;
    bus.c_wrl   = 1'b0;
    bus.c_wrh   = 1'b0;
    bus.c_din   = '0;
    do_reset();

    // Reset state and first cycle after release
    @(negedge clk);
    check("rst_c_ready", 64'(bus.c_ready), 64'(1));
    check("rst_c_rvalid", 64'(bus.c_rvalid), 64'(0));
    check("rst_c_dout", 64'(bus.c_dout), 64'(0));
    check("rst_m_addr", 64'(bus.m_addr), 64'(0));
    check("rst_m_req", 64'(bus.m_req), 64'(bus.m_ack));
    cyc(1);

    // Single read, slow controller returning 0xBEEF
    ref_mem[32'h100] = 16'hBEEF;
    ctl_mem[32'h100] = 16'hBEEF;
    fixed_delay = 6;
    send(24'h000100, 1'b0, 1'b0, 16'h0, ok);
    ready_low = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.c_rvalid === 1'b1) seen = 1'b1;
      else if (bus.c_ready !== 1'b0) ready_low = 1'b0;
    end
    check("read_ready_low", 64'(ready_low), 64'(1));
    check("read_rvalid_seen", 64'(seen), 64'(1));
    @(negedge clk);
    check("rvalid_one_pulse", 64'(bus.c_rvalid), 64'(0));
    check("c_dout_hold", 64'(bus.c_dout), 64'(16'hBEEF));
    cyc(1);
    fixed_delay = -1;

    // Five writes with the ack held: full after four, then in-order issue
    hold = 1'b1;
    i0 = issues;
    for (int i = 1; i <= 4; i++) send(24'(i), 1'b1, 1'b1, 16'(16'h1000 + i), ok);
    @(negedge clk);
    check("full_ready_low", 64'(bus.c_ready), 64'(0));
    cyc(1);
    fork
      send(24'd5, 1'b1, 1'b1, 16'h1005, ok);
      begin
        cyc(5);
        hold = 1'b0;
      end
    join
    drain();
    check("toggle_count", 64'(issues - i0), 64'(5));

    // Write then read of the same address: data comes back from the controller
    send(24'h0000A5, 1'b1, 1'b1, 16'h1234, ok);
    send(24'h0000A5, 1'b0, 1'b0, 16'h0, ok);
    drain();
    check("ctl_mem_written", 64'(ctl_mem[32'hA5]), 64'(16'h1234));

    // Accept and pop on the same edge at occupancy 2
    hold = 1'b1;
    send(24'h000040, 1'b1, 1'b1, 16'h4001, ok);
    send(24'h000041, 1'b1, 1'b1, 16'h4002, ok);
    cyc(2);
    release_one = 1'b1;
    send(24'h000042, 1'b1, 1'b1, 16'h4003, ok);
    @(negedge clk);
    check("pop_push_ready", 64'(bus.c_ready), 64'(1));
    cyc(1);
    send(24'h000043, 1'b1, 1'b1, 16'h4004, ok);
    @(negedge clk);
    check("pop_push_cnt3", 64'(bus.c_ready), 64'(1));
    cyc(1);
    send(24'h000044, 1'b1, 1'b1, 16'h4005, ok);
    @(negedge clk);
    check("pop_push_cnt4", 64'(bus.c_ready), 64'(0));
    cyc(1);
    hold = 1'b0;
    drain();

    // Byte writes to one address while the port is stalled
    hold = 1'b1;
    i0 = issues;
    send(24'h000010, 1'b1, 1'b1, 16'h5555, ok);
    cyc(2);
    send(24'h000020, 1'b1, 1'b0, 16'h00AA, ok);
    send(24'h000020, 1'b0, 1'b1, 16'hBB00, ok);
    hold = 1'b0;
    drain();
`ifdef SDRAM_RQ_MERGE_EN
    exp_n = 2;
`else
    exp_n = 3;
`endif
    check("merge_issue_count", 64'(issues - i0), 64'(exp_n));
    send(24'h000020, 1'b0, 1'b0, 16'h0, ok);
    drain();

    // Reset while waiting on the controller, then a stray late ack
    hold = 1'b1;
    send(24'h000030, 1'b1, 1'b1, 16'h7777, ok);
    cyc(3);
    do_reset();
    @(negedge clk);
    check("wait_rst_req_eq_ack", 64'(bus.m_req), 64'(bus.m_ack));
    check("wait_rst_ready", 64'(bus.c_ready), 64'(1));
    check("wait_rst_m_addr", 64'(bus.m_addr), 64'(0));
    cyc(1);
    ctl_off = 1'b1;
    i0 = rvalids;
    bus.m_ack = ~bus.m_ack;
    cyc(4);
    @(negedge clk);
    check("stray_req_eq_ack", 64'(bus.m_req), 64'(bus.m_ack));
    check("stray_no_rvalid", 64'(rvalids - i0), 64'(0));
    check("stray_ready", 64'(bus.c_ready), 64'(1));
    cyc(1);
    ctl_off = 1'b0;
    hold = 1'b0;
    send(24'h000031, 1'b1, 1'b1, 16'h8888, ok);
    send(24'h000031, 1'b0, 1'b0, 16'h0, ok);
    drain();

    // Randomized traffic over a small address set
    last_addr = '1;
    for (int n = 0; n < 200; n++) begin
      cyc(int'($urandom_range(0, 2)));
      a = 24'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a[24] = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        wl = 1'b0;
        wh = 1'b0;
      end else begin
        wl = 1'($urandom);
        wh = wl ? 1'($urandom) : 1'b1;
      end
`ifdef SDRAM_RQ_MERGE_EN
      if (a == last_addr) a = a ^ 24'h1;
`endif
      send(a, wl, wh, 16'($urandom), ok);
      last_addr = a;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
